// File: rtl/control_sequencer_if.sv
// Control-sequencer bundle: instruction/memory status in, datapath enables out.
// Latency: pure wiring, no state.
// Backpressure: none; Mem_Ready is the only stall input and is carried here.
//
// Ports (master = sequencer, slave = datapath):
//   Run, Mem_Ready, IR_Value                    status into the sequencer
//   PC_Out, ZLO_Out, MDR_Out                    bus-driver enables
//   MAR_In, PC_In, MDR_In, IR_In, Y_In, Z_In    register load enables
//   IncPC, Read, CONTROL                        ALU request, memory strobe, ALU op
//   Reg_In, Reg_Out                             one-hot general-register enables
//   Instr_Done, Halted, Illegal                 status
interface control_sequencer_if;
  logic        Run;
  logic        Mem_Ready;
  logic [31:0] IR_Value;

  logic        PC_Out;
  logic        ZLO_Out;
  logic        MDR_Out;
  logic        MAR_In;
  logic        PC_In;
  logic        MDR_In;
  logic        IR_In;
  logic        Y_In;
  logic        Z_In;
  logic        IncPC;
  logic        Read;
  logic [4:0]  CONTROL;
  logic [15:0] Reg_In;
  logic [15:0] Reg_Out;
  logic        Instr_Done;
  logic        Halted;
  logic        Illegal;

  modport master (
    input  Run, Mem_Ready, IR_Value,
    output PC_Out, ZLO_Out, MDR_Out, MAR_In, PC_In, MDR_In, IR_In, Y_In, Z_In,
           IncPC, Read, CONTROL, Reg_In, Reg_Out, Instr_Done, Halted, Illegal
  );

  modport slave (
    output Run, Mem_Ready, IR_Value,
    input  PC_Out, ZLO_Out, MDR_Out, MAR_In, PC_In, MDR_In, IR_In, Y_In, Z_In,
           IncPC, Read, CONTROL, Reg_In, Reg_Out, Instr_Done, Halted, Illegal
  );
endinterface

// File: rtl/control_sequencer.sv
// Moore FSM sequencing fetch (T0-T2, TW) and execute (T3-T5) for a 3-register CPU.
// Latency: one state per clock; ALU instruction 6 cycles + memory wait, NOP/illegal 4.
// Backpressure: Mem_Ready=0 in T1/TW holds the fetch in TW indefinitely.
//
// Ports:
//   Clock  system clock, rising edge
//   Clear  synchronous active-high reset to IDLE, overrides Run and Mem_Ready
//   bus    control_sequencer_if.master (status in, datapath enables out)
module control_sequencer (
  input  logic                  Clock,
  input  logic                  Clear,
  control_sequencer_if.master   bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_TW, S_T2, S_T3, S_T4, S_T5, S_HALT
  } state_t;

  localparam logic [4:0] OP_NOP  = 5'b11000;
  localparam logic [4:0] OP_HALT = 5'b11001;

  state_t state_q, state_d;

  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic        is_alu;
  logic [15:0] oh_ra, oh_rb, oh_rc;
  logic        unused_ir;

  assign opcode = bus.IR_Value[31:27];
  assign ra     = bus.IR_Value[26:23];
  assign rb     = bus.IR_Value[22:19];
  assign rc     = bus.IR_Value[18:15];
  // Opcodes 00000-10111 are ALU ops: everything whose top two bits are not 11.
  assign is_alu = (opcode[4:3] != 2'b11);
  assign oh_ra  = 16'd1 << ra;
  assign oh_rb  = 16'd1 << rb;
  assign oh_rc  = 16'd1 << rc;
  assign unused_ir = ^bus.IR_Value[14:0];

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    bus.PC_Out     = 1'b0;
    bus.ZLO_Out    = 1'b0;
    bus.MDR_Out    = 1'b0;
    bus.MAR_In     = 1'b0;
    bus.PC_In      = 1'b0;
    bus.MDR_In     = 1'b0;
    bus.IR_In      = 1'b0;
    bus.Y_In       = 1'b0;
    bus.Z_In       = 1'b0;
    bus.IncPC      = 1'b0;
    bus.Read       = 1'b0;
    bus.CONTROL    = 5'd0;
    bus.Reg_In     = 16'd0;
    bus.Reg_Out    = 16'd0;
    bus.Instr_Done = 1'b0;
    bus.Halted     = 1'b0;
    bus.Illegal    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.Run) state_d = S_T0;
      end
      S_T0: begin
        bus.PC_Out = 1'b1;
        bus.MAR_In = 1'b1;
        bus.IncPC  = 1'b1;
        bus.Z_In   = 1'b1;
        state_d    = S_T1;
      end
      S_T1: begin
        bus.ZLO_Out = 1'b1;
        bus.PC_In   = 1'b1;
        bus.Read    = 1'b1;
        bus.MDR_In  = 1'b1;
        state_d     = bus.Mem_Ready ? S_T2 : S_TW;
      end
      S_TW: begin
        // Keep the read strobe and MDR capture up until data arrives.
        bus.Read   = 1'b1;
        bus.MDR_In = 1'b1;
        if (bus.Mem_Ready) state_d = S_T2;
      end
      S_T2: begin
        bus.MDR_Out = 1'b1;
        bus.IR_In   = 1'b1;
        state_d     = S_T3;
      end
      S_T3: begin
        if (is_alu) begin
          bus.Reg_Out = oh_rb;
          bus.Y_In    = 1'b1;
          state_d     = S_T4;
        end else begin
          bus.Instr_Done = 1'b1;
          if (opcode == OP_HALT) begin
            state_d = S_HALT;
          end else begin
            // NOP and the reserved opcodes both end here; reserved ones flag Illegal.
            bus.Illegal = (opcode != OP_NOP);
            state_d     = bus.Run ? S_T0 : S_IDLE;
          end
        end
      end
      S_T4: begin
        bus.Reg_Out = oh_rc;
        bus.CONTROL = opcode;
        bus.Z_In    = 1'b1;
        state_d     = S_T5;
      end
      S_T5: begin
        bus.ZLO_Out    = 1'b1;
        bus.Reg_In     = oh_ra;
        bus.Instr_Done = 1'b1;
        state_d        = bus.Run ? S_T0 : S_IDLE;
      end
      S_HALT: begin
        bus.Halted = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle compare of every output.
// Latency: inputs applied after each edge, outputs sampled 2 time units later.
// Backpressure: Mem_Ready is driven low to force TW stalls.
module tb_control_sequencer;

  typedef struct packed {
    logic        pc_out;
    logic        zlo_out;
    logic        mdr_out;
    logic        mar_in;
    logic        pc_in;
    logic        mdr_in;
    logic        ir_in;
    logic        y_in;
    logic        z_in;
    logic        inc_pc;
    logic        read;
    logic [4:0]  control;
    logic [15:0] reg_in;
    logic [15:0] reg_out;
    logic        instr_done;
    logic        halted;
    logic        illegal;
  } out_t;

  logic Clock = 1'b0;
  logic Clear;
  logic mon_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  control_sequencer_if bus ();

  control_sequencer dut (
    .Clock (Clock),
    .Clear (Clear),
    .bus   (bus.master)
  );

  always #5 Clock = ~Clock;

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic out_t cur();
    out_t o;
    o.pc_out     = bus.PC_Out;
    o.zlo_out    = bus.ZLO_Out;
    o.mdr_out    = bus.MDR_Out;
    o.mar_in     = bus.MAR_In;
    o.pc_in      = bus.PC_In;
    o.mdr_in     = bus.MDR_In;
    o.ir_in      = bus.IR_In;
    o.y_in       = bus.Y_In;
    o.z_in       = bus.Z_In;
    o.inc_pc     = bus.IncPC;
    o.read       = bus.Read;
    o.control    = bus.CONTROL;
    o.reg_in     = bus.Reg_In;
    o.reg_out    = bus.Reg_Out;
    o.instr_done = bus.Instr_Done;
    o.halted     = bus.Halted;
    o.illegal    = bus.Illegal;
    return o;
  endfunction

  // Hand-written expected output word for each state.
  function automatic out_t e_idle();
    out_t o = '0;
    return o;
  endfunction
  function automatic out_t e_t0();
    out_t o = '0;
    o.pc_out = 1'b1; o.mar_in = 1'b1; o.inc_pc = 1'b1; o.z_in = 1'b1;
    return o;
  endfunction
  function automatic out_t e_t1();
    out_t o = '0;
    o.zlo_out = 1'b1; o.pc_in = 1'b1; o.read = 1'b1; o.mdr_in = 1'b1;
    return o;
  endfunction
  function automatic out_t e_tw();
    out_t o = '0;
    o.read = 1'b1; o.mdr_in = 1'b1;
    return o;
  endfunction
  function automatic out_t e_t2();
    out_t o = '0;
    o.mdr_out = 1'b1; o.ir_in = 1'b1;
    return o;
  endfunction
  function automatic out_t e_t3(input logic [15:0] ro);
    out_t o = '0;
    o.reg_out = ro; o.y_in = 1'b1;
    return o;
  endfunction
  function automatic out_t e_t4(input logic [15:0] ro, input logic [4:0] ctl);
    out_t o = '0;
    o.reg_out = ro; o.control = ctl; o.z_in = 1'b1;
    return o;
  endfunction
  function automatic out_t e_t5(input logic [15:0] ri);
    out_t o = '0;
    o.zlo_out = 1'b1; o.reg_in = ri; o.instr_done = 1'b1;
    return o;
  endfunction
  function automatic out_t e_t3end(input logic ill);
    out_t o = '0;
    o.instr_done = 1'b1; o.illegal = ill;
    return o;
  endfunction
  function automatic out_t e_halt();
    out_t o = '0;
    o.halted = 1'b1;
    return o;
  endfunction

  task automatic step(input string tag, input out_t exp);
    @(posedge Clock);
    #2;
    chk_eq(tag, 64'(cur()), 64'(exp));
  endtask

  // Bus-driver exclusivity and one-hot register enables, every cycle.
  always @(negedge Clock) begin
    if (mon_en) begin
      int drv;
      drv = $countones(bus.Reg_Out) + int'(bus.PC_Out) + int'(bus.ZLO_Out) + int'(bus.MDR_Out);
      chk_eq("one_driver", 64'(drv <= 1), 64'd1);
      chk_eq("reg_in_1hot", 64'($countones(bus.Reg_In) <= 1), 64'd1);
    end
  end

  initial begin
    Clear         = 1'b1;
    bus.Run       = 1'b0;
    bus.Mem_Ready = 1'b0;
    bus.IR_Value  = 32'h0;
    step("rst", e_idle());
    step("rst_hold", e_idle());
    Clear = 1'b0;
    step("idle", e_idle());
    mon_en = 1'b1;

    // Scenario 1: ALU op 01001, ra=5 rb=2 rc=4, no memory wait.
    bus.Run = 1'b1; bus.Mem_Ready = 1'b1; bus.IR_Value = 32'h4A920000;
    step("s1_t0", e_t0());
    step("s1_t1", e_t1());
    step("s1_t2", e_t2());
    step("s1_t3", e_t3(16'h0004));
    step("s1_t4", e_t4(16'h0010, 5'b01001));
    step("s1_t5", e_t5(16'h0020));

    // Scenario 2: three wait cycles; Mem_Ready toggled in T2/T3 is ignored.
    step("s2_t0", e_t0());
    bus.Mem_Ready = 1'b0;
    step("s2_t1", e_t1());
    step("s2_tw1", e_tw());
    step("s2_tw2", e_tw());
    step("s2_tw3", e_tw());
    bus.Mem_Ready = 1'b1;
    step("s2_t2", e_t2());
    bus.Mem_Ready = 1'b0;
    step("s2_t3", e_t3(16'h0004));
    step("s2_t4", e_t4(16'h0010, 5'b01001));
    bus.Mem_Ready = 1'b1;
    step("s2_t5", e_t5(16'h0020));
    bus.IR_Value = 32'hD0000000;

    // Scenario 4: reserved opcode 11010 acts as NOP with an Illegal pulse.
    step("s4_t0", e_t0());
    step("s4_t1", e_t1());
    step("s4_t2", e_t2());
    step("s4_t3", e_t3end(1'b1));
    step("s4_next_t0", e_t0());
    bus.IR_Value = 32'hC0000000;

    // NOP, then Run dropped at end of instruction.
    step("nop_t1", e_t1());
    step("nop_t2", e_t2());
    step("nop_t3", e_t3end(1'b0));
    bus.Run = 1'b0;
    step("nop_idle", e_idle());
    step("idle_hold", e_idle());

    // Scenario 5: ra=rb=rc=7, opcode 10111, Run dropped in T4.
    bus.IR_Value = 32'hBBBB8000; bus.Run = 1'b1;
    step("s5_t0", e_t0());
    step("s5_t1", e_t1());
    step("s5_t2", e_t2());
    step("s5_t3", e_t3(16'h0080));
    step("s5_t4", e_t4(16'h0080, 5'b10111));
    bus.Run = 1'b0;
    step("s5_t5", e_t5(16'h0080));
    step("s5_idle", e_idle());
    step("s5_idle2", e_idle());
    bus.Run = 1'b1;
    step("s5_rerun_t0", e_t0());

    // Scenario 6: Clear in T4 abandons the instruction.
    step("s6_t1", e_t1());
    step("s6_t2", e_t2());
    step("s6_t3", e_t3(16'h0080));
    step("s6_t4", e_t4(16'h0080, 5'b10111));
    Clear = 1'b1;
    step("s6_clr", e_idle());
    Clear = 1'b0; bus.Run = 1'b0;
    step("s6_no_t5", e_idle());
    step("s6_idle", e_idle());

    // Clear during TW beats Run and Mem_Ready.
    bus.Run = 1'b1; bus.Mem_Ready = 1'b0; bus.IR_Value = 32'hC8000000;
    step("twc_t0", e_t0());
    step("twc_t1", e_t1());
    step("twc_tw", e_tw());
    Clear = 1'b1; bus.Mem_Ready = 1'b1;
    step("twc_clr", e_idle());
    Clear = 1'b0;

    // Scenario 3: HALT holds regardless of Run until Clear.
    step("s3_t0", e_t0());
    step("s3_t1", e_t1());
    step("s3_t2", e_t2());
    step("s3_t3", e_t3end(1'b0));
    step("s3_halt", e_halt());
    for (int i = 0; i < 10; i++) begin
      bus.Run = i[0];
      step("s3_halt_hold", e_halt());
    end
    Clear = 1'b1; bus.Run = 1'b1;
    step("s3_clr", e_idle());
    Clear = 1'b0; bus.Run = 1'b0;
    step("s3_idle", e_idle());

    mon_en = 1'b0;
    @(posedge Clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Clock  in  1  system clock; all state changes on its rising edge.
REQ-002 Clear  in  1  synchronous, active-high reset.
REQ-003 Run  in  1  when 1, allows the next instruction fetch to start.
REQ-004 Mem_Ready  in  1  memory read-data valid; MData_In is valid in the same cycle.
REQ-005 IR_Value  in  32  current IR contents: opcode [31:27], ra [26:23], rb [22:19], rc [18:15].
REQ-006 PC_Out, ZLO_Out, MDR_Out  out  1 each  bus-driver enables.
REQ-007 MAR_In, PC_In, MDR_In, IR_In, Y_In, Z_In  out  1 each  register load enables.
REQ-008 IncPC, Read  out  1 each  PC-increment ALU request and memory read strobe.
REQ-009 CONTROL  out  5  ALU operation select.
REQ-010 Reg_In, Reg_Out  out  16 each  one-hot general-register load and drive enables.
REQ-011 Instr_Done  out  1  one-cycle pulse on the last cycle of each instruction.
REQ-012 Halted, Illegal  out  1 each  halt status; one-cycle illegal-opcode pulse.

Function
REQ-013 The block SHALL be a Moore FSM with states IDLE, T0, T1, TW, T2, T3, T4, T5, HALT, one state per clock.
REQ-014 Any output not listed for a state SHALL be 0; CONTROL SHALL be 0 except in T4.
REQ-015 IDLE: all outputs 0; goes to T0 when Run=1, otherwise stays in IDLE.
REQ-016 T0: PC_Out, MAR_In, IncPC, Z_In = 1; next state T1.
REQ-017 T1: ZLO_Out, PC_In, Read, MDR_In = 1; next state T2 if Mem_Ready=1, otherwise TW.
REQ-018 TW: Read and MDR_In = 1; stays in TW while Mem_Ready=0 with no limit; goes to T2 on Mem_Ready=1.
REQ-019 T2: MDR_Out and IR_In = 1; next state T3.
REQ-020 In T3, opcode SHALL be decoded from IR_Value sampled in that cycle.
REQ-021 ALU opcodes 00000-10111: T3 drives Reg_Out = one-hot(rb) and Y_In=1; next state T4.
REQ-022 T4: Reg_Out = one-hot(rc), CONTROL = opcode, Z_In=1; next state T5.
REQ-023 T5: ZLO_Out=1, Reg_In = one-hot(ra), Instr_Done=1.
REQ-024 NOP (11000): T3 drives no enables, Instr_Done=1, and the instruction ends.
REQ-025 HALT (11001): T3 asserts Instr_Done=1; next state HALT.
REQ-026 HALT: Halted=1, all other outputs 0; leaves HALT only on Clear.
REQ-027 Opcodes 11010-11111: handled as NOP, with Illegal=1 in T3.
REQ-028 End of instruction (T5, or T3 for NOP/illegal): next state T0 if Run=1, otherwise IDLE.
REQ-029 Reg_In and Reg_Out SHALL never have more than one bit set.
REQ-030 At most one bus driver (PC_Out, ZLO_Out, MDR_Out, any Reg_Out bit) SHALL be active in any cycle.
REQ-031 Mem_Ready outside T1 and TW SHALL be ignored.
REQ-032 Run changes SHALL be ignored except at IDLE and at end of instruction; an in-flight instruction always completes.
REQ-033 ra = rb = rc SHALL be legal; the enables are decoded unchanged.

Reset
REQ-034 When Clear=1 at a rising edge, the FSM SHALL enter IDLE from any state, including TW and HALT.
REQ-035 Outputs in the cycle after that edge SHALL be all 0, with Halted=0, Illegal=0 and CONTROL=0.
REQ-036 Clear SHALL take priority over Run and Mem_Ready.
REQ-037 An instruction interrupted by Clear SHALL be abandoned with no Reg_In or PC_In asserted afterwards.

Verification
REQ-038 Scenario 1: Run=1, Mem_Ready=1, IR_Value=0x4A920000 -> sequence T0,T1,T2,T3,T4,T5; T3 Reg_Out=0x0004 with Y_In; T4 Reg_Out=0x0010, CONTROL=01001; T5 Reg_In=0x0020 with Instr_Done.
REQ-039 Scenario 2: as Scenario 1 but Mem_Ready held low 3 cycles after T1 -> exactly 3 TW cycles with Read=MDR_In=1, then T2; PC_In asserted only in T1.
REQ-040 Scenario 3: IR_Value=0xC8000000 (HALT) -> Instr_Done in T3, then Halted=1 held for 10 or more cycles regardless of Run; Clear -> IDLE with Halted=0.
REQ-041 Scenario 4: IR_Value=0xD0000000 -> Illegal pulse for one cycle in T3, no Reg_In, next state T0.
REQ-042 Scenario 5: Run dropped during T4 -> T5 completes, then IDLE; Run reasserted -> T0 on the next cycle.
REQ-043 Scenario 6: Clear asserted in T4 -> next cycle IDLE with all outputs 0 and no T5 Reg_In pulse; check the one-driver assertion every cycle.
